axi_slave_mem: RTL and testbench

- AXI slave responder backed by a word-addressed on-chip memory.
- It is the responding end of the AXI channel set carried on the team's AXI virtual interface:
  - accepts AW/W and returns B;
  - accepts AR and returns R.
- It is the default DUT-side target for master-driver tests and lets the protocol assertions run against real handshakes.
- One outstanding transaction per direction. Read and write paths are fully independent.

---
 rtl/axi_slave_mem.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI slave responder backed by a byte-lane on-chip memory.
// One outstanding burst per direction; read and write paths are independent.
module axi_slave_mem #(
    parameter int C_AXI_ID_WIDTH   = 10,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_LEN_WIDTH  = 8,
    parameter int C_MEM_DEPTH_LOG2 = 10
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_AWLEN,
    input  logic [2:0]                    AXI_AWSIZE,
    input  logic [1:0]                    AXI_AWBURST,
    input  logic                          AXI_AWVALID,
    output logic                          AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                          AXI_WLAST,
    input  logic                          AXI_WVALID,
    output logic                          AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
    output logic [1:0]                    AXI_BRESP,
    output logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_ARLEN,
    input  logic [2:0]                    AXI_ARSIZE,
    input  logic [1:0]                    AXI_ARBURST,
    input  logic                          AXI_ARVALID,
    output logic                          AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    output logic [1:0]                    AXI_RRESP,
    output logic                          AXI_RLAST,
    output logic                          AXI_RVALID,
    input  logic                          AXI_RREADY
);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int HI     = OFF + C_MEM_DEPTH_LOG2;
    localparam int DEPTH  = 1 << C_MEM_DEPTH_LOG2;
    localparam logic [C_AXI_ADDR_WIDTH-1:0] STEP = C_AXI_ADDR_WIDTH'(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic in_range(input logic [C_AXI_ADDR_WIDTH-1:0] a);
        return (a >> HI) == '0;
    endfunction

    // ---------------- write path ----------------
    w_state_t r_wstate, w_wstate_next;
    logic r_awready, r_wready, r_bvalid;
    logic [C_AXI_ID_WIDTH-1:0]   r_wid;
    logic [C_AXI_ADDR_WIDTH-1:0] r_waddr;
    logic [C_AXI_LEN_WIDTH-1:0]  r_wlen, r_wcnt;
    logic r_wbad, r_wincr, r_werr;
    logic [1:0] r_bresp;
    logic w_aw_hs, w_w_hs, w_b_hs, w_wbeat_last, w_wbeat_ok, w_wbeat_err, w_mem_we;
    logic [C_MEM_DEPTH_LOG2-1:0] w_widx;

    assign w_aw_hs      = r_awready & AXI_AWVALID;
    assign w_w_hs       = r_wready & AXI_WVALID;
    assign w_b_hs       = r_bvalid & AXI_BREADY;
    assign w_wbeat_last = (r_wcnt == r_wlen);
    assign w_wbeat_ok   = !r_wbad && in_range(r_waddr);
    assign w_wbeat_err  = !w_wbeat_ok || (AXI_WLAST != w_wbeat_last);
    assign w_mem_we     = w_w_hs && w_wbeat_ok;
    assign w_widx       = r_waddr[HI-1:OFF];

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wbeat_last) w_wstate_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they stay low during reset.
    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awready <= (w_wstate_next == W_IDLE);
            r_wready  <= (w_wstate_next == W_DATA);
            r_bvalid  <= (w_wstate_next == W_RESP);
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_wid   <= '0;
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_wbad  <= 1'b0;
            r_wincr <= 1'b0;
            r_werr  <= 1'b0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_wid   <= AXI_AWID;
                r_waddr <= AXI_AWADDR;
                r_wlen  <= AXI_AWLEN;
                r_wcnt  <= '0;
                r_wbad  <= AXI_AWBURST[1];
                r_wincr <= (AXI_AWBURST == 2'b01);
                r_werr  <= 1'b0;
            end
            if (w_w_hs) begin
                if (r_wincr) r_waddr <= r_waddr + STEP;
                r_wcnt <= r_wcnt + 1'b1;
                r_werr <= r_werr | w_wbeat_err;
                if (w_wbeat_last) r_bresp <= (r_werr | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t r_rstate, w_rstate_next;
    logic r_arready, r_rvalid, r_rlast, r_rbad, r_rincr;
    logic [C_AXI_ID_WIDTH-1:0]   r_rid;
    logic [C_AXI_ADDR_WIDTH-1:0] r_raddr;
    logic [C_AXI_LEN_WIDTH-1:0]  r_rlen, r_rcnt;
    logic [1:0] r_rresp;
    logic w_ar_hs, w_r_hs, w_rd_load, w_rd_ok;
    logic [C_AXI_ADDR_WIDTH-1:0] w_rd_addr;
    logic [C_MEM_DEPTH_LOG2-1:0] w_ridx;

    assign w_ar_hs   = r_arready & AXI_ARVALID;
    assign w_r_hs    = r_rvalid & AXI_RREADY;
    assign w_rd_load = w_ar_hs | (w_r_hs & ~r_rlast);
    // r_raddr always holds the address of the beat to be loaded next.
    assign w_rd_addr = w_ar_hs ? AXI_ARADDR : r_raddr;
    assign w_rd_ok   = (w_ar_hs ? !AXI_ARBURST[1] : !r_rbad) && in_range(w_rd_addr);
    assign w_ridx    = w_rd_addr[HI-1:OFF];

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= (w_rstate_next == R_IDLE);
            r_rvalid  <= (w_rstate_next == R_DATA);
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            r_rid   <= '0;
            r_raddr <= '0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rbad  <= 1'b0;
            r_rincr <= 1'b0;
            r_rlast <= 1'b0;
            r_rresp <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rid   <= AXI_ARID;
                r_rlen  <= AXI_ARLEN;
                r_rcnt  <= '0;
                r_rbad  <= AXI_ARBURST[1];
                r_rincr <= (AXI_ARBURST == 2'b01);
                r_raddr <= AXI_ARADDR + ((AXI_ARBURST == 2'b01) ? STEP : '0);
                r_rlast <= (AXI_ARLEN == '0);
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_rcnt  <= r_rcnt + 1'b1;
                    r_raddr <= r_raddr + (r_rincr ? STEP : '0);
                    r_rlast <= ((r_rcnt + 1'b1) == r_rlen);
                end
            end
            if (w_rd_load) r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- storage: one byte-wide RAM per lane ----------------
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rbyte;

            always_ff @(posedge AXI_ACLK) begin
                if (w_mem_we && AXI_WSTRB[gi]) r_mem[w_widx] <= AXI_WDATA[gi*8 +: 8];
            end

            always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
                if (AXI_ARESET)     r_rbyte <= 8'h00;
                else if (w_rd_load) r_rbyte <= w_rd_ok ? r_mem[w_ridx] : 8'h00;
            end

            assign AXI_RDATA[gi*8 +: 8] = r_rbyte;
        end
    endgenerate

    logic w_unused;
    assign w_unused = ^{AXI_AWSIZE, AXI_ARSIZE};

    assign AXI_AWREADY = r_awready;
    assign AXI_WREADY  = r_wready;
    assign AXI_BVALID  = r_bvalid;
    assign AXI_BID     = r_wid;
    assign AXI_BRESP   = r_bresp;
    assign AXI_ARREADY = r_arready;
    assign AXI_RVALID  = r_rvalid;
    assign AXI_RID     = r_rid;
    assign AXI_RRESP   = r_rresp;
    assign AXI_RLAST   = r_rlast;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed + randomized bench for axi_slave_mem against a word-array reference model.
module tb_axi_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  AXI_AWID = '0, AXI_ARID = '0, AXI_BID, AXI_RID;
    logic [31:0] AXI_AWADDR = '0, AXI_ARADDR = '0, AXI_WDATA = '0, AXI_RDATA;
    logic [7:0]  AXI_AWLEN = '0, AXI_ARLEN = '0;
    logic [2:0]  AXI_AWSIZE = '0, AXI_ARSIZE = '0;
    logic [1:0]  AXI_AWBURST = '0, AXI_ARBURST = '0, AXI_BRESP, AXI_RRESP;
    logic [3:0]  AXI_WSTRB = '0;
    logic AXI_AWVALID = 0, AXI_WLAST = 0, AXI_WVALID = 0, AXI_BREADY = 0;
    logic AXI_ARVALID = 0, AXI_RREADY = 0;
    logic AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RLAST, AXI_RVALID;

    axi_slave_mem #(
        .C_AXI_ID_WIDTH(10), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32),
        .C_AXI_LEN_WIDTH(8), .C_MEM_DEPTH_LOG2(10)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN),
        .AXI_AWSIZE(AXI_AWSIZE), .AXI_AWBURST(AXI_AWBURST),
        .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST),
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARID(AXI_ARID), .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN),
        .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RID(AXI_RID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST),
        .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] model [1024];
    logic [31:0] bdata [256];
    logic [3:0]  bstrb [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b01) ? a + 32'(i * 4) : a;
    endfunction

    function automatic bit beat_ok(input logic [31:0] a, input logic [1:0] burst);
        return (burst[1] == 1'b0) && (a[31:12] == 20'd0);
    endfunction

    function automatic logic [63:0] outs_vec();
        return {2'b00, AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BID, AXI_BRESP, AXI_ARREADY,
                AXI_RVALID, AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST};
    endfunction

    function automatic logic [63:0] r_vec();
        return {17'd0, AXI_RVALID, AXI_RLAST, AXI_RRESP, AXI_RID, AXI_RDATA};
    endfunction

    // Data/strobes come from bdata/bstrb; early >= 0 raises WLAST on that beat.
    task automatic write_burst(input logic [9:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input int early, input int bhold, input bit gaps);
        int n;
        bit err;
        logic [31:0] a;
        err = 0;
        @(negedge clk);
        check("wready_idle", AXI_WREADY, 0);
        AXI_AWID = id; AXI_AWADDR = addr; AXI_AWLEN = 8'(len); AXI_AWSIZE = 3'd2;
        AXI_AWBURST = burst; AXI_AWVALID = 1;
        n = 0;
        while (AXI_AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("aw_timeout", 64'(n < 50), 1);
        @(negedge clk);
        AXI_AWVALID = 0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin AXI_WVALID = 0; @(negedge clk); end
            AXI_WDATA = bdata[i]; AXI_WSTRB = bstrb[i];
            AXI_WLAST = (i == len) || (i == early);
            AXI_WVALID = 1;
            n = 0;
            while (AXI_WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            check("w_timeout", 64'(n < 50), 1);
            @(negedge clk);
            a = beat_addr(addr, burst, i);
            if (beat_ok(a, burst)) begin
                for (int b = 0; b < 4; b++)
                    if (bstrb[i][b]) model[a[11:2]][8*b +: 8] = bdata[i][8*b +: 8];
            end else begin
                err = 1;
            end
            if (i == early && i != len) err = 1;
        end
        AXI_WVALID = 0; AXI_WLAST = 0;
        check("bvalid_latency", AXI_BVALID, 1);
        check("wready_drop", AXI_WREADY, 0);
        for (int c = 0; c < bhold; c++) begin
            @(negedge clk);
            check("bvalid_hold", AXI_BVALID, 1);
            check("bid_hold", AXI_BID, id);
            check("awready_hold", AXI_AWREADY, 0);
        end
        check("bid", AXI_BID, id);
        check("bresp", AXI_BRESP, err ? 64'd2 : 64'd0);
        AXI_BREADY = 1;
        @(negedge clk);
        AXI_BREADY = 0;
        check("bvalid_drop", AXI_BVALID, 0);
        check("awready_back", AXI_AWREADY, 1);
        $display("WRITE id=%0d addr=%08h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, AXI_BRESP);
    endtask

    task automatic read_burst(input logic [9:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input bit toggle);
        int n, i;
        bit held;
        logic [31:0] a;
        logic [63:0] hv;
        @(negedge clk);
        AXI_ARID = id; AXI_ARADDR = addr; AXI_ARLEN = 8'(len); AXI_ARSIZE = 3'd2;
        AXI_ARBURST = burst; AXI_ARVALID = 1;
        n = 0;
        while (AXI_ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("ar_timeout", 64'(n < 50), 1);
        @(negedge clk);
        AXI_ARVALID = 0;
        check("rvalid_latency", AXI_RVALID, 1);
        i = 0; n = 0; held = 0; hv = '0;
        while (i <= len && n < 400) begin
            if (held) check("r_hold", r_vec(), hv);
            if (!toggle) check("rvalid_b2b", AXI_RVALID, 1);
            AXI_RREADY = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (AXI_RVALID === 1'b1 && AXI_RREADY) begin
                a = beat_addr(addr, burst, i);
                check("rdata", AXI_RDATA, beat_ok(a, burst) ? 64'(model[a[11:2]]) : 64'd0);
                check("rresp", AXI_RRESP, beat_ok(a, burst) ? 64'd0 : 64'd2);
                check("rlast", AXI_RLAST, 64'(i == len));
                check("rid", AXI_RID, id);
                i++; held = 0;
            end else begin
                held = (AXI_RVALID === 1'b1);
                hv = r_vec();
            end
            @(negedge clk);
            n++;
        end
        check("r_beats", 64'(i), 64'(len + 1));
        AXI_RREADY = 0;
        check("rvalid_drop", AXI_RVALID, 0);
        check("rlast_drop", AXI_RLAST, 0);
        check("arready_back", AXI_ARREADY, 1);
        $display("READ  id=%0d addr=%08h len=%0d burst=%0d beats=%0d", id, addr, len, burst, i);
    endtask

    task automatic fill(input int len, input logic [3:0] strb);
        for (int i = 0; i <= len; i++) begin bdata[i] = $urandom; bstrb[i] = strb; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rb;
        int rl;
        // reset state and release timing
        #12;
        check("reset_outs", outs_vec(), 0);
        @(negedge clk); rst = 0; #1;
        check("ready_after_release_low", {AXI_AWREADY, AXI_ARREADY}, 0);
        @(negedge clk);
        check("awready_rise", AXI_AWREADY, 1);
        check("arready_rise", AXI_ARREADY, 1);

        // preload every word so all later reads have a known reference
        for (int blk = 0; blk < 4; blk++) begin
            fill(255, 4'hF);
            write_burst(10'(blk), 32'(blk * 32'h400), 255, 2'b01, -1, 0, 0);
        end

        // single write then readback
        bdata[0] = 32'hDEADBEEF; bstrb[0] = 4'hF;
        write_burst(10'd5, 32'h10, 0, 2'b01, -1, 0, 0);
        read_burst(10'd9, 32'h10, 0, 2'b01, 0);

        // INCR LEN=3, back-to-back readback
        for (int i = 0; i < 4; i++) begin bdata[i] = 32'(i + 1); bstrb[i] = 4'hF; end
        write_burst(10'd1, 32'h100, 3, 2'b01, -1, 0, 0);
        read_burst(10'd2, 32'h100, 3, 2'b01, 0);

        // partial strobe merge
        bdata[0] = 32'h11223344; bstrb[0] = 4'hF;
        write_burst(10'd3, 32'h20, 0, 2'b01, -1, 0, 0);
        bdata[0] = 32'hAABBCCDD; bstrb[0] = 4'b0101;
        write_burst(10'd3, 32'h20, 0, 2'b01, -1, 0, 0);
        read_burst(10'd3, 32'h20, 0, 2'b01, 0);

        // error cases: WRAP write, out-of-range read, early WLAST
        fill(1, 4'hF);
        write_burst(10'd7, 32'h30, 1, 2'b10, -1, 0, 0);
        read_burst(10'd7, 32'h30, 1, 2'b01, 0);
        read_burst(10'd8, 32'h0001_0000, 0, 2'b01, 0);
        fill(3, 4'hF);
        write_burst(10'd11, 32'h200, 3, 2'b01, 1, 0, 0);
        read_burst(10'd11, 32'h200, 3, 2'b01, 0);

        // B backpressure, then LEN=7 read with RREADY toggling
        fill(0, 4'hF);
        write_burst(10'h2A5, 32'h40, 0, 2'b01, -1, 5, 0);
        read_burst(10'd4, 32'h100, 7, 2'b01, 1);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            ra = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
            rl = $urandom_range(0, 7);
            rb = 2'($urandom_range(0, 3));
            for (int i = 0; i <= rl; i++) begin bdata[i] = $urandom; bstrb[i] = 4'($urandom); end
            write_burst(10'($urandom), ra, rl, rb, ($urandom_range(0, 4) == 0) ? $urandom_range(0, rl) : -1,
                        $urandom_range(0, 3), 1);
            read_burst(10'($urandom), ra, rl, (rb == 2'b00) ? 2'b00 : 2'b01, 1'($urandom_range(0, 1)));
        end

        // reset while a write awaits data and a read is mid-burst
        @(negedge clk);
        AXI_AWID = 10'd1; AXI_AWADDR = 32'h300; AXI_AWLEN = 8'd3; AXI_AWBURST = 2'b01; AXI_AWVALID = 1;
        AXI_ARID = 10'd2; AXI_ARADDR = 32'h100; AXI_ARLEN = 8'd7; AXI_ARBURST = 2'b01; AXI_ARVALID = 1;
        @(negedge clk);
        AXI_AWVALID = 0; AXI_ARVALID = 0; AXI_RREADY = 1;
        check("both_accepted", {AXI_WREADY, AXI_RVALID}, 2'b11);
        @(negedge clk);
        AXI_RREADY = 0;
        check("mid_burst", AXI_RVALID, 1);
        #2 rst = 1; #1;
        check("reset_mid_outs", outs_vec(), 0);
        @(negedge clk); rst = 0; #1;
        check("ready_low_at_release", {AXI_AWREADY, AXI_ARREADY}, 0);
        @(negedge clk);
        check("ready_back", {AXI_AWREADY, AXI_ARREADY}, 2'b11);
        repeat (3) begin
            @(negedge clk);
            check("no_stale_resp", {AXI_BVALID, AXI_RVALID, AXI_WREADY}, 0);
        end
        $display("RESET mid-burst recovered");

        fill(1, 4'hF);
        write_burst(10'd12, 32'h300, 1, 2'b01, -1, 0, 0);
        read_burst(10'd13, 32'h300, 1, 2'b01, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
